mem_access_unit: RTL and testbench

Parametrised MEM-stage data-memory access unit for the pipelined RISC-V core. It performs RV32I byte, halfword and word loads and stores over a req/gnt/rvalid handshake, so data memory may take several cycles. While an access is outstanding it stalls the pipeline. It also flags misaligned accesses and bus timeouts, and returns the sign- or zero-extended load result to MEM/WB.

---
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: RV32I byte/halfword/word loads and
// stores over a req/gnt/rvalid handshake. The unit stalls the pipeline while
// an access is outstanding, flags misaligned or unsupported accesses, times
// out stuck bus transactions and returns the extended load result to MEM/WB.
module mem_access_unit #(
  parameter int REG_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MemRead,
  input  logic                        MemWrite,
  input  logic [2:0]                  funct3,
  input  logic [REG_DATA_WIDTH-1:0]   ALU_result,
  input  logic [REG_DATA_WIDTH-1:0]   reg_read_data,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [REG_DATA_WIDTH/8-1:0] mem_be,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [REG_DATA_WIDTH-1:0]   mem_wdata,
  input  logic                        mem_gnt,
  input  logic                        mem_rvalid,
  input  logic [REG_DATA_WIDTH-1:0]   mem_rdata,
  output logic                        mem_stall,
  output logic                        misaligned,
  output logic                        bus_error,
  output logic [REG_DATA_WIDTH-1:0]   mem_data_o_WB
);

  localparam int NB = REG_DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t                      state_reg, state_next;
  logic                        req_reg, req_next;
  logic                        we_reg, we_next;
  logic [NB-1:0]               be_reg, be_next;
  logic [MEM_ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [REG_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [REG_DATA_WIDTH-1:0]   wb_reg, wb_next;
  logic                        misaligned_reg, misaligned_next;
  logic                        bus_error_reg, bus_error_next;
  logic [CW-1:0]               cnt_reg, cnt_next;
  logic [1:0]                  off_reg, off_next;
  logic [2:0]                  f3_reg, f3_next;

  logic                        access;
  logic                        supported;
  logic                        aligned;
  logic [1:0]                  offset;
  logic [NB-1:0]               be_lane;
  logic [REG_DATA_WIDTH-1:0]   wdata_lane;
  logic [REG_DATA_WIDTH-1:0]   rdata_shift;
  logic [15:0]                 rdata_half;
  logic [REG_DATA_WIDTH-1:0]   load_ext;
  logic [CW-1:0]               cnt_inc;
  logic                        timeout;

  assign offset  = ALU_result[1:0];
  assign access  = MemRead | MemWrite;
  assign cnt_inc = cnt_reg + CW'(1);
  assign timeout = (cnt_inc == CW'(TIMEOUT_CYCLES));

  // Decode size legality, alignment and the store lane placement.
  always_comb begin
    supported  = 1'b0;
    aligned    = 1'b0;
    be_lane    = '1;
    wdata_lane = reg_read_data;
    // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
    case (funct3)
      3'b000, 3'b001, 3'b010: supported = 1'b1;
      3'b100, 3'b101:         supported = ~MemWrite;
      default:                supported = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        aligned    = 1'b1;
        be_lane    = NB'(1) << offset;
        wdata_lane = {4{reg_read_data[7:0]}};
      end
      2'b01: begin
        aligned    = ~offset[0];
        be_lane    = NB'(3) << offset;
        wdata_lane = {2{reg_read_data[15:0]}};
      end
      2'b10:   aligned = (offset == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Pick the addressed byte/halfword from the raw read word and extend it.
  always_comb begin
    rdata_shift = mem_rdata >> {off_reg, 3'b000};
    rdata_half  = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_reg)
      3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b100:  load_ext = {24'h000000, rdata_shift[7:0]};
      3'b001:  load_ext = {{16{rdata_half[15]}}, rdata_half};
      3'b101:  load_ext = {16'h0000, rdata_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and output logic of the access sequencer.
  always_comb begin
    state_next      = state_reg;
    req_next        = req_reg;
    we_next         = we_reg;
    be_next         = be_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    wb_next         = wb_reg;
    misaligned_next = 1'b0;
    bus_error_next  = 1'b0;
    cnt_next        = cnt_reg;
    off_next        = off_reg;
    f3_next         = f3_reg;
    mem_stall       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access) begin
          if (supported && aligned) begin
            mem_stall  = 1'b1;
            addr_next  = MEM_ADDR_WIDTH'({ALU_result[REG_DATA_WIDTH-1:2], 2'b00});
            we_next    = MemWrite;
            be_next    = be_lane;
            wdata_next = wdata_lane;
            req_next   = 1'b1;
            off_next   = offset;
            f3_next    = funct3;
            cnt_next   = '0;
            state_next = REQ;
          end else begin
            // Misaligned or unsupported: report it and let the pipeline move on.
            misaligned_next = 1'b1;
            wb_next         = '0;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (mem_gnt) begin
          // Read data can never arrive with the grant; wait for it separately.
          req_next   = 1'b0;
          cnt_next   = '0;
          state_next = we_reg ? DONE : WAIT_R;
        end else if (timeout) begin
          bus_error_next = 1'b1;
          req_next       = 1'b0;
          wb_next        = '0;
          state_next     = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      WAIT_R: begin
        mem_stall = 1'b1;
        if (mem_rvalid) begin
          wb_next    = load_ext;
          state_next = DONE;
        end else if (timeout) begin
          bus_error_next = 1'b1;
          wb_next        = '0;
          state_next     = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      be_reg         <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wb_reg         <= '0;
      misaligned_reg <= 1'b0;
      bus_error_reg  <= 1'b0;
      cnt_reg        <= '0;
      off_reg        <= 2'b00;
      f3_reg         <= 3'b000;
    end else begin
      state_reg      <= state_next;
      req_reg        <= req_next;
      we_reg         <= we_next;
      be_reg         <= be_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      wb_reg         <= wb_next;
      misaligned_reg <= misaligned_next;
      bus_error_reg  <= bus_error_next;
      cnt_reg        <= cnt_next;
      off_reg        <= off_next;
      f3_reg         <= f3_next;
    end
  end

  assign mem_req       = req_reg;
  assign mem_we        = we_reg;
  assign mem_be        = be_reg;
  assign mem_addr      = addr_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_data_o_WB = wb_reg;
  assign misaligned    = misaligned_reg;
  assign bus_error     = bus_error_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// accesses checked against a behavioural model of RV32I load/store lanes.
module tb_mem_access_unit;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALU_result, reg_read_data;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_stall, misaligned, bus_error;
  logic [31:0] mem_data_o_WB;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_load = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .REG_DATA_WIDTH(32), .MEM_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALU_result(ALU_result), .reg_read_data(reg_read_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .misaligned(misaligned),
    .bus_error(bus_error), .mem_data_o_WB(mem_data_o_WB)
  );

  // Reference model: value a load returns from a raw word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int o, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input int o);
    case (f3)
      3'b000:  return 4'(1 << o);
      3'b001:  return 4'(3 << o);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return (d & 32'hFF) * 32'h01010101;
      3'b001:  return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // Drive one aligned access through the handshake. gw = REQ cycles without
  // grant; rw = WAIT_R cycles without rvalid.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int gw, input int rw,
                            output logic [31:0] res, output int nstall);
    int req_cyc, wait_cyc, exp_stall, o;
    bit done;
    logic [31:0] exp_res;
    o = int'(addr & 32'h3);
    exp_res   = st ? last_load : ref_load(f3, o, rd);
    exp_stall = 2 + gw + (st ? 0 : rw + 1);
    req_cyc = 0; wait_cyc = 0; nstall = 0; done = 0;
    @(negedge clk);
    MemRead = ld; MemWrite = st; funct3 = f3; ALU_result = addr; reg_read_data = wd;
    mem_gnt = 0; mem_rvalid = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (!mem_stall) begin done = 1; break; end
      nstall++;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (mem_req) begin
        req_cyc++;
        checks++;
        if (mem_addr !== (addr & 32'hFFFFFFFC) || mem_we !== st) begin
          failures++;
          $display("FAIL req_fields addr=%h we=%b required addr=%h we=%b", mem_addr, mem_we, addr & 32'hFFFFFFFC, st);
        end
        if (st) begin
          checks++;
          if (mem_be !== ref_be(f3, o) || mem_wdata !== ref_wdata(f3, wd)) begin
            failures++;
            $display("FAIL store_lanes be=%b wdata=%h required be=%b wdata=%h", mem_be, mem_wdata, ref_be(f3, o), ref_wdata(f3, wd));
          end
        end
        if (req_cyc > gw) begin
          mem_gnt = 1;
          if (!st) begin mem_rvalid = 1; mem_rdata = ~rd; end
        end
      end else if (cyc > 0) begin
        wait_cyc++;
        if (wait_cyc > rw) begin mem_rvalid = 1; mem_rdata = rd; end
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL access_timeout stall still high after 200 cycles, required release");
    end
    checks++;
    if (nstall != exp_stall || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_cycles got=%0d req=%b required=%0d req=0", nstall, mem_req, exp_stall);
    end
    checks++;
    if (mem_data_o_WB !== exp_res) begin
      failures++;
      $display("FAIL wb_result f3=%b addr=%h got=%h required=%h", f3, addr, mem_data_o_WB, exp_res);
    end
    res = mem_data_o_WB;
    last_load = exp_res;
    mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
    MemRead = 0; MemWrite = 0;
    #1;
    checks++;
    if (mem_data_o_WB !== last_load || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL wb_hold got=%h stall=%b required=%h stall=0", mem_data_o_WB, mem_stall, last_load);
    end
    $display("txn ld=%b st=%b f3=%b addr=%h wd=%h rd=%h gw=%0d rw=%0d wb=%h stall=%0d",
             ld, st, f3, addr, wd, rd, gw, rw, res, nstall);
  endtask

  task automatic test_reset();
    rst = 1; MemRead = 0; MemWrite = 0; funct3 = 0; ALU_result = 0; reg_read_data = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_data_o_WB, misaligned, bus_error, mem_stall} !== '0) begin
      failures++;
      $display("FAIL reset_state req=%b we=%b be=%b addr=%h wdata=%h wb=%h mis=%b berr=%b stall=%b required all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_data_o_WB, misaligned, bus_error, mem_stall);
    end
    rst = 0;
    $display("txn reset");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    MemRead = 1; funct3 = 3'b010; ALU_result = 32'h40;
    @(negedge clk);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; rst = 1; MemRead = 0;
    @(negedge clk);
    rst = 0; mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state req=%b stall=%b required 0 0", mem_req, mem_stall);
    end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    checks++;
    if (mem_data_o_WB !== 32'h0 || mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_late_rvalid wb=%h req=%b stall=%b required 0 0 0", mem_data_o_WB, mem_req, mem_stall);
    end
    last_load = 0;
    $display("txn reset_mid_wait_r wb=%h", mem_data_o_WB);
  endtask

  task automatic test_plan_cases();
    logic [31:0] r;
    int ns;
    run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, r, ns);
    checks++;
    if (ns != 3) begin
      failures++;
      $display("FAIL sw_stall got=%0d required=3", ns);
    end
    run_access(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, r, ns);
    run_access(1, 0, 3'b000, 32'h102, 32'h0, 32'h12F03456, 0, 1, r, ns);
    checks++;
    if (r !== 32'hFFFFFFF0) begin failures++; $display("FAIL lb_plan got=%h required=FFFFFFF0", r); end
    run_access(1, 0, 3'b100, 32'h102, 32'h0, 32'h12F03456, 1, 0, r, ns);
    checks++;
    if (r !== 32'h000000F0) begin failures++; $display("FAIL lbu_plan got=%h required=000000F0", r); end
    run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h12F03456, 0, 0, r, ns);
    checks++;
    if (r !== 32'h000012F0) begin failures++; $display("FAIL lh_plan got=%h required=000012F0", r); end
    // Both controls high behaves as a store.
    run_access(1, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 0, 0, r, ns);
  endtask

  task automatic test_random();
    logic [2:0] fsel [5];
    logic [31:0] r, a;
    logic [2:0] f;
    logic st;
    int ns;
    fsel[0] = 3'b000; fsel[1] = 3'b001; fsel[2] = 3'b010; fsel[3] = 3'b100; fsel[4] = 3'b101;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      f  = st ? fsel[$urandom_range(0, 2)] : fsel[$urandom_range(0, 4)];
      a  = $urandom;
      if (f[1:0] == 2'b01) a[0] = 1'b0;
      if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      run_access(~st, st, f, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), r, ns);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0] f3s [3];
    logic [31:0] as [3];
    f3s[0] = 3'b010; as[0] = 32'h101;   // LW misaligned
    f3s[1] = 3'b101; as[1] = 32'h203;   // LHU misaligned
    f3s[2] = 3'b011; as[2] = 32'h300;   // unsupported size
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      MemRead = 1; MemWrite = 0; funct3 = f3s[i]; ALU_result = as[i];
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin failures++; $display("FAIL mis_stall case=%0d got=%b required=0", i, mem_stall); end
      @(negedge clk);
      MemRead = 0;
      #1;
      checks++;
      if (misaligned !== 1'b1 || mem_req !== 1'b0 || mem_data_o_WB !== 32'h0) begin
        failures++;
        $display("FAIL mis_pulse case=%0d mis=%b req=%b wb=%h required 1 0 0", i, misaligned, mem_req, mem_data_o_WB);
      end
      @(negedge clk);
      #1;
      checks++;
      if (misaligned !== 1'b0 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL mis_one_cycle case=%0d mis=%b req=%b required 0 0", i, misaligned, mem_req);
      end
      last_load = 0;
      $display("txn misaligned f3=%b addr=%h", f3s[i], as[i]);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    int ns;
    // Leave a nonzero result behind so the clearing is observable.
    run_access(1, 0, 3'b010, 32'h80, 32'h0, 32'hCAFEF00D, 0, 0, r, ns);
    @(negedge clk);
    MemRead = 1; funct3 = 3'b010; ALU_result = 32'h200;
    @(negedge clk);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    for (int k = 0; k < TO; k++) begin
      #1;
      checks++;
      if (bus_error !== 1'b0 || mem_stall !== 1'b1) begin
        failures++;
        $display("FAIL timeout_early k=%0d berr=%b stall=%b required 0 1", k, bus_error, mem_stall);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus_error !== 1'b1 || mem_stall !== 1'b0 || mem_data_o_WB !== 32'h0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire berr=%b stall=%b wb=%h req=%b required 1 0 0 0", bus_error, mem_stall, mem_data_o_WB, mem_req);
    end
    @(negedge clk);
    MemRead = 0;
    #1;
    checks++;
    if (bus_error !== 1'b0) begin failures++; $display("FAIL timeout_pulse berr=%b required=0", bus_error); end
    last_load = 0;
    $display("txn timeout after %0d wait cycles", TO);
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_plan_cases();
    test_random();
    test_misaligned();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
